uart_time_cmd: RTL and testbench

//  Command layer between uart_top and the clock core. Consumes received bytes (data_out/rx_done),

---
 rtl/uart_cmd_pkg.sv | 58 +++++
 rtl/uart_resp_tx.sv | 58 +++++
 rtl/uart_time_cmd.sv | 141 ++++++++++++++
 tb/tb_uart_time_cmd.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, types and response byte ROM for the UART time command layer.
package uart_cmd_pkg;

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_E     = 8'h45;

  typedef enum logic [1:0] {RSP_OK, RSP_ER, RSP_TIME} rsp_e;
  typedef enum logic [1:0] {P_IDLE, P_SET, P_RDCR, P_DISCARD} pstate_e;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAIT} tstate_e;

  typedef struct packed {
    rsp_e        code;
    logic [23:0] snap;   // BCD hh:mm:ss, only meaningful for RSP_TIME
  } rsp_req_t;

  function automatic logic [7:0] bcd_asc(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [3:0] rsp_last(input rsp_e code);
    return (code == RSP_TIME) ? 4'd9 : 4'd3;
  endfunction

  function automatic logic [7:0] rsp_byte(input rsp_e code, input logic [3:0] idx,
                                          input logic [23:0] snap);
    logic [7:0] b;
    b = CH_LF;
    if (code == RSP_TIME) begin
      case (idx)
        4'd0: b = bcd_asc(snap[23:20]);
        4'd1: b = bcd_asc(snap[19:16]);
        4'd2: b = CH_COLON;
        4'd3: b = bcd_asc(snap[15:12]);
        4'd4: b = bcd_asc(snap[11:8]);
        4'd5: b = CH_COLON;
        4'd6: b = bcd_asc(snap[7:4]);
        4'd7: b = bcd_asc(snap[3:0]);
        4'd8: b = CH_CR;
        default: b = CH_LF;
      endcase
    end else begin
      case (idx)
        4'd0: b = (code == RSP_OK) ? CH_O : CH_E;
        4'd1: b = (code == RSP_OK) ? CH_K : CH_R;
        4'd2: b = CH_CR;
        default: b = CH_LF;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Response sequencer: walks the bytes of one queued response through the UART transmitter.
module uart_resp_tx
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_vld,
  input  rsp_req_t              req,
  input  logic                  tx_done,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy
);

  tstate_e  tst;
  rsp_req_t cur;
  logic [3:0] bidx;

  // tx_start is a default-low pulse; T_LOAD always sits between pulses so the gap is >= 1 cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tst      <= T_IDLE;
      cur      <= '0;
      bidx     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (tst)
        T_IDLE: if (req_vld) begin
          cur  <= req;
          bidx <= '0;
          busy <= 1'b1;
          tst  <= T_LOAD;
        end
        T_LOAD: begin
          tx_data  <= rsp_byte(cur.code, bidx, cur.snap);
          tx_start <= 1'b1;
          tst      <= T_WAIT;
        end
        T_WAIT: if (tx_done) begin
          if (bidx == rsp_last(cur.code)) begin
            busy <= 1'b0;
            tst  <= T_IDLE;
          end else begin
            bidx <= bidx + 4'd1;
            tst  <= T_LOAD;
          end
        end
        default: tst <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_time_cmd.sv
// ASCII set/read-time command parser sitting between uart_top and the clock core.
module uart_time_cmd
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDLE_TO    = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_done,
  input  logic [7:0]            cur_h,
  input  logic [7:0]            cur_m,
  input  logic [7:0]            cur_s,
  output logic                  set_stb,
  output logic [7:0]            set_h,
  output logic [7:0]            set_m,
  output logic [7:0]            set_s,
  output logic                  busy
);

  localparam int TW = $clog2(IDLE_TO + 1);

  pstate_e     pst;
  logic [3:0]  idx;
  logic [23:0] fld;
  logic [TW-1:0] to_cnt;
  rsp_req_t    req;
  logic        req_vld;
  logic        rx_ok, is_digit, range_ok;

  // Half-duplex host: bytes arriving while a response is in flight are dropped.
  assign rx_ok    = rx_done & ~busy;
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign range_ok = (fld[23:20] <= 4'd2) && ((fld[23:20] != 4'd2) || (fld[19:16] <= 4'd3)) &&
                    (fld[15:12] <= 4'd5) && (fld[7:4] <= 4'd5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pst     <= P_IDLE;
      idx     <= '0;
      fld     <= '0;
      to_cnt  <= '0;
      req     <= '0;
      req_vld <= 1'b0;
      set_stb <= 1'b0;
      set_h   <= '0;
      set_m   <= '0;
      set_s   <= '0;
    end else begin
      set_stb <= 1'b0;
      req_vld <= 1'b0;
      if (rx_ok) begin
        to_cnt <= '0;
        case (pst)
          P_IDLE: begin
            if (rx_data == CH_T) begin
              pst <= P_SET;
              idx <= 4'd1;
            end else if (rx_data == CH_R) begin
              pst <= P_RDCR;
            end else if (rx_data == CH_CR) begin
              req.code <= RSP_ER;
              req_vld  <= 1'b1;
            end else begin
              pst <= P_DISCARD;
            end
          end
          P_SET: begin
            if (rx_data == CH_CR) begin
              if (idx == 4'd9 && range_ok) begin
                set_stb  <= 1'b1;
                set_h    <= fld[23:16];
                set_m    <= fld[15:8];
                set_s    <= fld[7:0];
                req.code <= RSP_OK;
              end else begin
                req.code <= RSP_ER;
              end
              req_vld <= 1'b1;
              pst     <= P_IDLE;
            end else if (idx == 4'd3 || idx == 4'd6) begin
              if (rx_data == CH_COLON) idx <= idx + 4'd1;
              else                     pst <= P_DISCARD;
            end else if (idx == 4'd9 || !is_digit) begin
              pst <= P_DISCARD;
            end else begin
              case (idx)
                4'd1: fld[23:20] <= rx_data[3:0];
                4'd2: fld[19:16] <= rx_data[3:0];
                4'd4: fld[15:12] <= rx_data[3:0];
                4'd5: fld[11:8]  <= rx_data[3:0];
                4'd7: fld[7:4]   <= rx_data[3:0];
                default: fld[3:0] <= rx_data[3:0];
              endcase
              idx <= idx + 4'd1;
            end
          end
          P_RDCR: begin
            if (rx_data == CH_CR) begin
              req.code <= RSP_TIME;
              req.snap <= {cur_h, cur_m, cur_s};
              req_vld  <= 1'b1;
              pst      <= P_IDLE;
            end else begin
              pst <= P_DISCARD;
            end
          end
          default: if (rx_data == CH_CR) begin
            req.code <= RSP_ER;
            req_vld  <= 1'b1;
            pst      <= P_IDLE;
          end
        endcase
      end else if (pst != P_IDLE) begin
        // A stalled partial command is abandoned without any response.
        if (to_cnt == TW'(IDLE_TO - 1)) begin
          pst    <= P_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  uart_resp_tx #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
    .clk      (clk),
    .reset    (reset),
    .req_vld  (req_vld),
    .req      (req),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy)
  );

endmodule

// File: tb/tb_uart_time_cmd.sv
// Scoreboard bench for uart_time_cmd with a simple UART transmitter responder.
module tb_uart_time_cmd;

  localparam int IDLE_TO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] cur_h, cur_m, cur_s;
  logic       set_stb;
  logic [7:0] set_h, set_m, set_s;
  logic       busy;

  int vectors = 0;
  int errors  = 0;
  logic [7:0]  exp_tx[$];
  logic [23:0] exp_set[$];
  logic        outstanding;

  always #5 clk = ~clk;

  uart_time_cmd #(.DATA_WIDTH(8), .IDLE_TO(IDLE_TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .set_stb(set_stb), .set_h(set_h), .set_m(set_m), .set_s(set_s), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART responder: tx_done five cycles after each tx_start.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !reset) begin
        repeat (5) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a set strobe.
  initial begin
    outstanding = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        outstanding = 1'b0;
      end else begin
        if (tx_done) outstanding = 1'b0;
        if (tx_start) begin
          check("tx_start_before_done", {31'd0, outstanding}, 32'd0);
          outstanding = 1'b1;
          if (exp_tx.size() == 0) begin
            vectors++; errors++;
            $display("FAIL tx_unexpected: got byte %0h, expected no byte", tx_data);
          end else begin
            check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
          end
        end
        if (set_stb) begin
          if (exp_set.size() == 0) begin
            vectors++; errors++;
            $display("FAIL set_unexpected: got %0h, expected no set_stb", {set_h, set_m, set_s});
          end else begin
            check("set_value", {8'd0, set_h, set_m, set_s}, {8'd0, exp_set.pop_front()});
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h0D);
  endtask

  task automatic push_ok();
    exp_tx.push_back(8'h4F); exp_tx.push_back(8'h4B);
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
  endtask

  task automatic push_er();
    exp_tx.push_back(8'h45); exp_tx.push_back(8'h52);
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
  endtask

  task automatic push_read(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    exp_tx.push_back(8'h30 + {4'h0, h[7:4]}); exp_tx.push_back(8'h30 + {4'h0, h[3:0]});
    exp_tx.push_back(8'h3A);
    exp_tx.push_back(8'h30 + {4'h0, m[7:4]}); exp_tx.push_back(8'h30 + {4'h0, m[3:0]});
    exp_tx.push_back(8'h3A);
    exp_tx.push_back(8'h30 + {4'h0, s[7:4]}); exp_tx.push_back(8'h30 + {4'h0, s[3:0]});
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (4) @(negedge clk);
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_tx_drained"}, exp_tx.size(), 32'd0);
    check({name, "_set_drained"}, exp_set.size(), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; rx_data = '0; rx_done = 1'b0;
    cur_h = '0; cur_m = '0; cur_s = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_set", {7'd0, set_stb, set_h, set_m, set_s}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: valid set
    exp_set.push_back(24'h123456);
    push_ok();
    send_cmd("T12:34:56");
    wait_idle("t1");
    check("t1_set_hold", {8'd0, set_h, set_m, set_s}, 32'h00123456);

    // 2: read, snapshot must not follow cur mid-response
    cur_h = 8'h23; cur_m = 8'h59; cur_s = 8'h07;
    exp_tx.push_back(8'h32); exp_tx.push_back(8'h33); exp_tx.push_back(8'h3A);
    exp_tx.push_back(8'h35); exp_tx.push_back(8'h39); exp_tx.push_back(8'h3A);
    exp_tx.push_back(8'h30); exp_tx.push_back(8'h37); exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
    send_cmd("R");
    wait_busy("t2");
    cur_h = 8'h11; cur_m = 8'h22; cur_s = 8'h33;
    wait_idle("t2");

    // 3: range errors and junk
    push_er(); send_cmd("T24:00:00"); wait_idle("t3a");
    push_er(); send_cmd("T12:60:00"); wait_idle("t3b");
    push_er(); send_cmd("X1");        wait_idle("t3c");
    check("t3_set_hold", {8'd0, set_h, set_m, set_s}, 32'h00123456);

    // 4: partial command times out silently
    send_byte(8'h54); send_byte(8'h31); send_byte(8'h32); send_byte(8'h3A); send_byte(8'h33);
    repeat (IDLE_TO + 10) @(negedge clk);
    check("t4_silent", {31'd0, busy}, 32'd0);
    cur_h = 8'h12; cur_m = 8'h05; cur_s = 8'h09;
    push_read(8'h12, 8'h05, 8'h09);
    send_cmd("R");
    wait_idle("t4");

    // 5: byte while busy is dropped
    cur_h = 8'h01; cur_m = 8'h02; cur_s = 8'h03;
    push_read(8'h01, 8'h02, 8'h03);
    send_cmd("R");
    wait_busy("t5");
    n = 0;
    while (exp_tx.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("t5_last_byte_seen", exp_tx.size(), 32'd0);
    check("t5_still_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h54);
    wait_idle("t5a");
    push_read(8'h01, 8'h02, 8'h03);
    send_cmd("R");
    wait_idle("t5b");

    // 6: async reset during T_WAIT of an OK response
    exp_set.push_back(24'h081500);
    push_ok();
    send_cmd("T08:15:00");
    n = 0;
    while (exp_tx.size() != 3 && n < 200) begin @(negedge clk); n++; end
    check("t6_first_byte", exp_tx.size(), 32'd3);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_set", {8'd0, set_h, set_m, set_s}, 32'd0);
    exp_tx.delete();
    exp_set.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    cur_h = 8'h10; cur_m = 8'h20; cur_s = 8'h30;
    push_read(8'h10, 8'h20, 8'h30);
    send_cmd("R");
    wait_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
